// File: rtl/ultrasonic_echo_timer_if.sv
// Handshake bundle between the ranging controller and the echo timer.
// The master side drives start/echo; the slave side returns the result.
interface ultrasonic_echo_timer_if;
    logic       start;
    logic       echo;
    logic       trigger;
    logic [7:0] count;
    logic       calculate;
    logic       busy;
    logic       timeout;

    modport master (
        output start, echo,
        input  trigger, count, calculate, busy, timeout
    );

    modport slave (
        input  start, echo,
        output trigger, count, calculate, busy, timeout
    );
endinterface

// File: rtl/ultrasonic_echo_timer.sv
// Ultrasonic trigger/echo timer producing an 8-bit tick count.
// Define ULTRA_AUTO_RETRIGGER_EN for free-running measurements.
module ultrasonic_echo_timer #(
    parameter int unsigned TRIG_CYCLES      = 500,
    parameter int unsigned TICK_CYCLES      = 1450,
    parameter int unsigned ECHO_WAIT_CYCLES = 1500000,
    parameter int unsigned HOLDOFF_CYCLES   = 3000000
) (
    input logic                    clk,
    input logic                    reset,
    ultrasonic_echo_timer_if.slave bus
);

    localparam int unsigned MAX_A =
        (TRIG_CYCLES > ECHO_WAIT_CYCLES) ?
        TRIG_CYCLES : ECHO_WAIT_CYCLES;
    localparam int unsigned MAX_C =
        (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
    localparam int CW = $clog2(MAX_C + 1);
    localparam int PW =
        (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(ECHO_WAIT_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CYCLES - 1);
`ifdef ULTRA_AUTO_RETRIGGER_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_FIN, S_HOLD
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_FIN
    } state_e;
`endif

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] pre_q;
    logic [7:0]    tick_q;
    logic          sync_q, echo_s_q, echo_d_q;
    logic          rise_d, fall_d, rise_q, fall_q;
    logic          trig_q, calc_q, busy_q, to_q;
    logic [7:0]    count_q;

    always_comb begin
        rise_d = echo_s_q & ~echo_d_q;
        fall_d = ~echo_s_q & echo_d_q;
    end

    // Edge flags are registered so the FSM never sees a metastable path.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 1'b0;
            echo_s_q <= 1'b0;
            echo_d_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= bus.echo;
            echo_s_q <= sync_q;
            echo_d_q <= echo_s_q;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            tick_q  <= '0;
            trig_q  <= 1'b0;
            calc_q  <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            count_q <= '0;
        end else begin
            calc_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_TRIG;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        state_q <= S_WAIT;
                        trig_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (rise_q) begin
                        state_q <= S_MEAS;
                        pre_q   <= '0;
                        tick_q  <= '0;
                    end else if (cnt_q == WAIT_LAST) begin
                        state_q <= S_FIN;
                        count_q <= 8'hFF;
                        to_q    <= 1'b1;
                        calc_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_MEAS: begin
                    if (fall_q) begin
                        state_q <= S_FIN;
                        count_q <= tick_q;
                        to_q    <= 1'b0;
                        calc_q  <= 1'b1;
                    end else if (pre_q == PRE_LAST) begin
                        pre_q <= '0;
                        // The 255th tick is over-range.
                        if (tick_q == 8'd254) begin
                            state_q <= S_FIN;
                            count_q <= 8'hFF;
                            to_q    <= 1'b1;
                            calc_q  <= 1'b1;
                        end else begin
                            tick_q <= tick_q + 8'd1;
                        end
                    end else begin
                        pre_q <= pre_q + PW'(1);
                    end
                end
                S_FIN: begin
`ifdef ULTRA_AUTO_RETRIGGER_EN
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
`else
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
`endif
                end
`ifdef ULTRA_AUTO_RETRIGGER_EN
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= S_TRIG;
                        trig_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger   = trig_q;
    assign bus.count     = count_q;
    assign bus.calculate = calc_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = to_q;

endmodule
